// File: rtl/mul_wb_pkg.sv
// Shared constants for the shift-add multiplier: state codes (also decoded by the control unit) and default widths.
package mul_wb_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int ADR_W_DEF = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MUL   = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3
  } state_e;

endpackage

// File: rtl/mul_wb_unit_if.sv
// Request/result/RAM-write bundle between the control unit (master) and mul_wb_unit (slave).
// No backpressure: the master must watch busy, since start is dropped outside IDLE.
interface mul_wb_unit_if
  import mul_wb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ADR_W = ADR_W_DEF
) ();

  logic               start;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [ADR_W-1:0]   wr_adr;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;
  logic               ram_we;
  logic [ADR_W-1:0]   ram_adr;
  logic [2*WIDTH-1:0] ram_din;
  logic [2:0]         st_out;

  modport master (
    output start, op_a, op_b, wr_adr,
    input  busy, done, product, ram_we, ram_adr, ram_din, st_out
  );

  modport slave (
    input  start, op_a, op_b, wr_adr,
    output busy, done, product, ram_we, ram_adr, ram_din, st_out
  );

endinterface

// File: rtl/mul_wb_unit_shift_add_dp.sv
// Shift-add datapath: load captures operands, each step adds/shifts once; last flags the final step.
// One step per cycle, no backpressure; the FSM owns sequencing.
module shift_add_dp
  import mul_wb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic [2*WIDTH-1:0] acc,
  output logic               last
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  always_comb begin
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (load) begin
      mcand_d  = {{WIDTH{1'b0}}, op_a};
      mplier_d = op_b;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (step) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign acc  = acc_q;
  assign last = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/mul_wb_unit.sv
// Unsigned shift-add multiplier with single-cycle RAM write-back; start-to-done latency WIDTH+2 cycles.
// No backpressure: start is accepted only in IDLE and never queued.
module mul_wb_unit
  import mul_wb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ADR_W = ADR_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  mul_wb_unit_if.slave bus
);

  state_e             state_q, state_d;
  logic [ADR_W-1:0]   adr_q, adr_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [2*WIDTH-1:0] acc;
  logic               load, step, last;

  assign load = (state_q == ST_IDLE) && bus.start;
  assign step = (state_q == ST_MUL);

  shift_add_dp #(.WIDTH(WIDTH)) u_dp (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .step  (step),
    .op_a  (bus.op_a),
    .op_b  (bus.op_b),
    .acc   (acc),
    .last  (last)
  );

  assign adr_d     = load ? bus.wr_adr : adr_q;
  assign product_d = (state_q == ST_WRITE) ? acc : product_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      adr_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      product_q <= product_d;
    end
  end

  // last is checked before the step lands, so MUL spans exactly WIDTH cycles
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_MUL;
      ST_MUL:   if (last) state_d = ST_WRITE;
      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy    = (state_q != ST_IDLE);
    bus.done    = (state_q == ST_DONE);
    bus.ram_we  = (state_q == ST_WRITE);
    bus.ram_adr = (state_q == ST_WRITE) ? adr_q : '0;
    bus.ram_din = (state_q == ST_WRITE) ? acc : '0;
    bus.st_out  = state_q;
    bus.product = product_q;
  end

endmodule

// File: tb/tb_mul_wb_unit.sv
// Directed bench for mul_wb_unit at WIDTH=4, ADR_W=3 with hand-computed products and cycle positions.
module tb_mul_wb_unit;

  localparam int W = 4;
  localparam int A = 3;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   we_cyc_prev;

  always #5 clk = ~clk;

  mul_wb_unit_if #(.WIDTH(W), .ADR_W(A)) bus ();

  mul_wb_unit #(.WIDTH(W), .ADR_W(A)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic [2:0] adr,
                       input logic [7:0] expv, input bit hold, input bit disturb,
                       output int we_cyc);
    int we_cnt, we_at, done_at, done_cnt;
    bus.start  = 1'b1;
    bus.op_a   = a;
    bus.op_b   = b;
    bus.wr_adr = adr;
    tick();
    if (!hold) bus.start = 1'b0;
    check_val("busy_after_accept", bus.busy, 1);
    check_val("st_after_accept", bus.st_out, 1);
    we_cnt = 0; we_at = -1; done_at = -1; done_cnt = 0; we_cyc = -1;
    for (int k = 1; k <= W + 2; k++) begin
      if (disturb && k == 1) begin
        bus.start  = 1'b1;
        bus.op_a   = 4'd2;
        bus.op_b   = 4'd3;
        bus.wr_adr = 3'd1;
      end
      if (disturb && k == 3) bus.start = 1'b0;
      tick();
      if (bus.ram_we) begin
        we_cnt++;
        we_at  = k;
        we_cyc = cyc;
        check_val("ram_adr", bus.ram_adr, adr);
        check_val("ram_din", bus.ram_din, expv);
      end else begin
        check_val("ram_din_idle_zero", bus.ram_din, 0);
      end
      if (bus.done) begin
        done_cnt++;
        done_at = k;
        check_val("product_at_done", bus.product, expv);
      end
    end
    check_val("ram_we_count", we_cnt, 1);
    check_val("ram_we_edge", we_at, W);
    check_val("done_count", done_cnt, 1);
    check_val("done_edge", done_at, W + 1);
    check_val("st_back_idle", bus.st_out, 0);
    check_val("product_hold", bus.product, expv);
  endtask

  initial begin
    int we_c, d_cnt, w_cnt;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.op_a   = '0;
    bus.op_b   = '0;
    bus.wr_adr = '0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (5) tick();
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_done", bus.done, 0);
    check_val("rst_product", bus.product, 0);
    check_val("rst_ram_we", bus.ram_we, 0);
    check_val("rst_ram_adr", bus.ram_adr, 0);
    check_val("rst_ram_din", bus.ram_din, 0);
    check_val("rst_st", bus.st_out, 0);

    do_op(4'd13, 4'd11, 3'd5, 8'd143, 1'b0, 1'b0, we_c);
    do_op(4'd15, 4'd15, 3'd7, 8'd225, 1'b0, 1'b0, we_c);
    do_op(4'd0,  4'd9,  3'd2, 8'd0,   1'b0, 1'b0, we_c);
    do_op(4'd1,  4'd1,  3'd0, 8'd1,   1'b0, 1'b0, we_c);
    repeat (2) tick();
    do_op(4'd13, 4'd11, 3'd5, 8'd143, 1'b0, 1'b1, we_c);

    // abort in MUL: product must fall from 143 to 0
    bus.start = 1'b1; bus.op_a = 4'd5; bus.op_b = 4'd5; bus.wr_adr = 3'd3;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check_val("pre_abort_st", bus.st_out, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("abort_st", bus.st_out, 0);
    check_val("abort_busy", bus.busy, 0);
    check_val("abort_product", bus.product, 0);
    check_val("abort_ram_we", bus.ram_we, 0);
    check_val("abort_done", bus.done, 0);
    d_cnt = 0; w_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.done) d_cnt++;
      if (bus.ram_we) w_cnt++;
    end
    check_val("abort_no_done", d_cnt, 0);
    check_val("abort_no_we", w_cnt, 0);

    do_op(4'd3, 4'd4, 3'd6, 8'd12, 1'b1, 1'b0, we_c);
    we_cyc_prev = we_c;
    do_op(4'd7, 4'd2, 3'd1, 8'd14, 1'b0, 1'b0, we_c);
    check_val("b2b_spacing", we_c - we_cyc_prev, W + 3);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mul_wb_unit.md
# mul_wb_unit

Sequential shift-add multiplier with RAM write-back, sitting directly downstream of the control unit's operand-fetch states. It captures two register-file operands and a destination RAM address on a one-cycle `start` strobe, then computes the unsigned product over WIDTH cycles. It writes the product to the data RAM with a single-cycle write-enable and signals completion with a one-cycle `done` pulse.

## Interface
- `WIDTH`, default 4: unsigned operand width in bits; the product is 2*WIDTH bits.
- `ADR_W`, default 3: RAM address width.
- `clk`  in  1  rising-edge clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `op_a`  in  WIDTH  multiplicand from the register file.
- `op_b`  in  WIDTH  multiplier from the register file.
- `wr_adr`  in  ADR_W  destination RAM address.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `product`  out  2*WIDTH  last completed product; holds between operations.
- `ram_we`  out  1  RAM write enable.
- `ram_adr`  out  ADR_W  RAM address; valid while `ram_we` is high.
- `ram_din`  out  2*WIDTH  RAM write data; valid while `ram_we` is high.
- `st_out`  out  3  state code: IDLE=0, MUL=1, WRITE=2, DONE=3.

## Operation
- Moore FSM with four states: IDLE, MUL, WRITE, DONE.
- IDLE: when `start`=1 at a clock edge:
  - capture `op_a` into `mcand` (2*WIDTH bits, zero-extended), `op_b` into `mplier`, and `wr_adr` into `adr_q`;
  - clear `acc` and `cnt`;
  - go to MUL.
- With `start`=0, IDLE holds.
- MUL, every cycle:
  - if `mplier[0]`, then `acc <= acc + mcand`;
  - `mcand <<= 1`, `mplier >>= 1`, `cnt++`;
  - when `cnt` reaches WIDTH-1 on this edge, go to WRITE.
  - MUL therefore lasts exactly WIDTH cycles.
- Arithmetic:
  - `acc` is 2*WIDTH bits wide.
  - No overflow is possible, since (2^WIDTH-1)^2 < 2^(2*WIDTH).
  - `cnt` is $clog2(WIDTH)+1 bits wide.
- WRITE: `ram_we`=1, `ram_adr`=`adr_q`, `ram_din`=`acc`; `product <= acc` on the exiting edge; go to DONE.
- DONE: `done`=1; go to IDLE unconditionally.
- `start` is ignored outside IDLE; it is not queued.
- A `start` held high in IDLE on the cycle after DONE begins a new operation; back-to-back operations are legal.
- Operand inputs are sampled only on the accepting edge; later changes have no effect on the running operation.
- Zero operand (either operand 0): the full MUL sequence still runs; a product of 0 is written.
- Reset, from any state:
  - next state is IDLE;
  - `acc`, `mcand`, `mplier`, `cnt`, `adr_q` and `product` are cleared;
  - an operation in flight is aborted with no RAM write and no `done`.
- Outputs after reset: `busy`=0, `done`=0, `product`=0, `ram_we`=0, `ram_adr`=0, `ram_din`=0, `st_out`=0.

## Timing
- Define edge 0 as the edge that accepts `start`.
- MUL occupies the cycles after edges 0 .. WIDTH-1.
- WRITE is the cycle after edge WIDTH: `ram_we` is high for exactly that one cycle.
- DONE is the cycle after edge WIDTH+1: `done` is high for exactly that one cycle, and `product` is already valid.
- IDLE resumes after edge WIDTH+2.
- Start-to-done latency is WIDTH+2 cycles; throughput is one operation per WIDTH+3 cycles.
- `busy`, `done`, `ram_we` and `st_out` are decoded from the state register only; there are no combinational paths from inputs to outputs.
- `ram_adr` and `ram_din` are driven from `adr_q`/`acc` only in WRITE and are 0 otherwise.

## Structure
- Shared package `mul_wb_pkg` holds:
  - the state encoding constants ST_IDLE=3'd0, ST_MUL=3'd1, ST_WRITE=3'd2, ST_DONE=3'd3, shared with the control unit's `st_out` decoding;
  - default WIDTH/ADR_W localparams.
- One sub-module, `shift_add_dp`: holds the `mcand`/`mplier`/`acc`/`cnt` registers.
  - Inputs: `clk`, `reset`, `load`, `step`, `op_a`, `op_b`.
  - Outputs: `acc`, `last` (high when `cnt`==WIDTH-1).
- The FSM stays in `mul_wb_unit`.

## Test plan
- Reset, then idle for 5 cycles: all outputs are 0; `st_out`=0; `busy`=0.
- WIDTH=4, `op_a`=13, `op_b`=11, `wr_adr`=5, one-cycle `start`:
  - `busy` rises the next cycle;
  - `ram_we` pulses once, 5 cycles after `start` is sampled, with `ram_adr`=5 and `ram_din`=143;
  - `done` pulses the following cycle;
  - `product`=143.
- Corner operands:
  - 15×15 → `ram_din`=225;
  - 0×9 → `ram_din`=0, with the full 6-cycle latency;
  - 1×1 → 1.
- Mid-operation disturbance:
  - `start` re-asserted and operands changed during MUL → ignored; result equals the original operands' product.
  - `reset` asserted in MUL (cycle 2) → next cycle IDLE, no `ram_we`, no `done`, `product`=0.
- Back-to-back: `start` held high continuously with 3×4 then 7×2 → two RAM writes (12, then 14) spaced 7 cycles apart, each followed by `done`.
